// File: rtl/cenn_accumulator.sv
// cenn_accumulator: sums TERMS signed products per cell update, clamps the sum and presents it under valid/ready.
// Define CENN_ACC_PWL_EN to clamp to the CeNN piecewise-linear output (+/-1.0) instead of the full WIDTH range.
module cenn_accumulator #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 9,
    parameter int TERMS = 19,
    parameter int ACC_W = WIDTH + $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);
    localparam int CW = $clog2(TERMS);
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;
`ifdef CENN_ACC_PWL_EN
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(1 << FRAC);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(-(1 << FRAC));
`else
    localparam logic signed [ACC_W-1:0] HI = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(-(1 << (WIDTH-1)));
`endif

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d, take, sat_hi, sat_lo;

    always_comb begin
        sum = acc_q + ACC_W'(signed'(in_data));
        take = in_valid && state_q == ACCUM && !clear;
        sat_hi = sum > HI;
        sat_lo = sum < LO;
        state_d = state_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_data_d = out_data_q;
        out_sat_d = out_sat_q;
        if (state_q == ACCUM && clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (take && cnt_q == CW'(TERMS-1)) begin
            state_d = HOLD;
            acc_d = '0;
            cnt_d = '0;
            out_data_d = sat_hi ? HI[WIDTH-1:0] : sat_lo ? LO[WIDTH-1:0] : sum[WIDTH-1:0];
            out_sat_d = sat_hi || sat_lo;
        end else if (take) begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q <= '0;
            cnt_q <= '0;
            out_data_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign in_ready = state_q == ACCUM;
    assign out_valid = state_q == HOLD;
    assign out_data = out_data_q;
    assign out_sat = out_sat_q;
endmodule

// File: tb/tb_cenn_accumulator.sv
// tb_cenn_accumulator: directed and randomized updates checked against an integer sum-and-clamp reference.
module tb_cenn_accumulator;
    localparam int WIDTH = 15;
    localparam int FRAC  = 9;
    localparam int TERMS = 19;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, clear, out_valid, out_ready, out_sat;
    logic signed [WIDTH-1:0] in_data, out_data;
    int n_tests = 0;
    int n_fail = 0;
    int tq[$];

    always #5 clk = ~clk;

    cenn_accumulator #(.WIDTH(WIDTH), .FRAC(FRAC), .TERMS(TERMS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_ref(input int s, output bit sat);
`ifdef CENN_ACC_PWL_EN
        int hi = 1 << FRAC;
        int lo = -(1 << FRAC);
`else
        int hi = (1 << (WIDTH-1)) - 1;
        int lo = -(1 << (WIDTH-1));
`endif
        sat = s > hi || s < lo;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int v);
        tq = {};
        repeat (TERMS) tq.push_back(v);
    endtask

    // Presents every term in tq; a gap may follow any term except the last.
    task automatic feed(input int gap_pct, input bit hold_valid, output int s);
        s = 0;
        for (int i = 0; i < tq.size(); i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(tq[i]);
            tick();
            s += tq[i];
            if (i == TERMS-2) check("early_valid", out_valid, 0);
            if (i < TERMS-1 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = hold_valid;
        in_data = WIDTH'(12345);
    endtask

    task automatic drain(input string tag, input int s, input int stall);
        bit sat;
        int e;
        e = clamp_ref(s, sat);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_data"}, out_data, e);
        check({tag, "_sat"}, out_sat, sat);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_stall_valid"}, out_valid, 1);
            check({tag, "_stall_in_ready"}, in_ready, 0);
            check({tag, "_stall_data"}, out_data, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check({tag, "_consumed"}, out_valid, 0);
        check({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        int s, m;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        clear = 1'b0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        fill(512);        feed(0, 1'b0, s);   drain("ones", s, 0);
        fill(16383);      feed(0, 1'b0, s);   drain("pos_full", s, 0);
        fill(-16384);     feed(0, 1'b0, s);   drain("neg_full", s, 0);
        fill(-256);       feed(100, 1'b0, s); drain("alt_gap", s, 0);
        fill(300);        feed(0, 1'b1, s);   drain("stall", s, 5);
        fill(-20);        feed(0, 1'b0, s);   drain("after_stall", s, 0);

        fill(100);
        tq = tq[0:6];
        feed(0, 1'b1, s);
        in_data = WIDTH'(100);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fill(10);         feed(0, 1'b0, s);   drain("clear_mid", s, 0);

        fill(100);
        tq = tq[0:6];
        feed(0, 1'b0, s);
        reset = 1'b1;
        #2;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_out_sat", out_sat, 0);
        tick();
        reset = 1'b0;
        fill(10);         feed(0, 1'b0, s);   drain("rst_mid", s, 0);

        fill(16383);      feed(0, 1'b0, s);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        drain("clear_hold", s, 1);

        fill(512);        feed(0, 1'b0, s);
        check("hold_before_rst", out_valid, 1);
        reset = 1'b1;
        #2;
        check("rst_hold_out_valid", out_valid, 0);
        check("rst_hold_out_data", out_data, 0);
        check("rst_hold_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            case ($urandom_range(3))
                0: m = 64;
                1: m = 1024;
                2: m = 8192;
                default: m = 16383;
            endcase
            tq = {};
            repeat (TERMS) tq.push_back(int'($urandom_range(2 * m)) - m);
            feed(30, 1'b0, s);
            drain($sformatf("rand%0d", r), s, int'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cenn_accumulator.md
# cenn_accumulator

Downstream companion of the signed fixed-point multiplier in the CeNN cell datapath. It takes the stream of registered Q5.9 products for one cell update: 9 feedback-template terms, 9 control-template terms and 1 bias term. It sums them in a widened accumulator and saturates the sum back to the datapath width. It then presents the new cell state under a valid/ready handshake to the state-update stage.

## Interface
- WIDTH, 15: datapath word width, signed two's complement.
- FRAC, 9: fractional bits (Q5.9 at defaults); 1.0 = 512.
- TERMS, 19: products summed per cell update.
- ACC_W, WIDTH+$clog2(TERMS) (20): internal accumulator width.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a product term this cycle.
- in_ready  out  1  block can accept a term this cycle.
- in_data  in  WIDTH  signed product term, straight from the multiplier output register.
- clear  in  1  synchronous abort; discards the partial sum.
- out_valid  out  1  out_data holds a finished cell result.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  WIDTH  saturated/clamped sum.
- out_sat  out  1  clamping changed the result; qualified by out_valid.

## Operation
- FSM states:
  - ACCUM: in_ready=1. Each accepted term (in_valid&in_ready) does acc += sign_extend(in_data) and cnt++.
  - HOLD: in_ready=0, out_valid=1.
- Transitions:
  - On the accepted term with cnt==TERMS-1: register sum=acc+in_data, clamp it, load out_data/out_sat, zero acc and cnt, go to HOLD.
  - HOLD→ACCUM on out_valid&out_ready.
- Gaps in in_valid are allowed; acc and cnt hold their values.
- in_valid is ignored in HOLD. The upstream controller must stall the multiplier.
- Clamp without macro: sum>2^(WIDTH-1)-1 → 16383; sum<-2^(WIDTH-1) → -16384; otherwise sum[WIDTH-1:0]. out_sat=1 iff clamped.
- No arithmetic shift; the products already carry FRAC fractional bits.
- ACC_W guarantees no internal wrap for TERMS terms at full scale.
- clear:
  - In ACCUM: zero acc and cnt; any term presented that cycle is dropped.
  - In HOLD: ignored; the result stays until handshaken.
- clear and reset are the only ways to abandon a partial sum.

## Timing
- Reset values:
  - state=ACCUM, acc=0, cnt=0.
  - in_ready=1, out_valid=0, out_data=0, out_sat=0.
- Latency: out_valid rises on the cycle after the last term is accepted (1 cycle). Minimum update period is TERMS+1 cycles.
- Handshake:
  - out_data/out_sat are stable while out_valid=1 and out_ready=0.
  - A result is consumed on the clk edge where out_valid&out_ready=1.
  - in_ready returns to 1 in the following cycle; there is no combinational ready-to-ready path.
- out_ready asserted while out_valid=0 has no effect.
- Reset asserted mid-accumulation or in HOLD: outputs drop to reset values immediately (asynchronous). The partial sum is lost and the count restarts at 0 after reset release.

## Configuration
- CENN_ACC_PWL_EN defined:
  - Clamp uses the standard CeNN piecewise-linear output y=0.5(|x+1|-|x-1|).
  - sum>(1<<FRAC) → 512; sum<-(1<<FRAC) → -512.
  - out_sat=1 when either limit applies.
  - The block then emits cell output y rather than state x.
- Not defined: the full-range WIDTH saturation above. The PWL logic is absent.

## Test plan
- 19 terms of 512 (1.0), no gaps, out_ready=1:
  - out_valid rises in cycle 20.
  - out_data=9728, out_sat=0.
  - With PWL: out_data=512, out_sat=1.
- 19 terms of 16383:
  - out_data=16383, out_sat=1.
  - 19 terms of -16384 → out_data=-16384 (0x4000), out_sat=1.
  - With PWL: 512 and -512 respectively.
- Alternating in_valid (1,0,1,0…) with 19 terms of -256:
  - Single result out_data=-4864 (with PWL: -512).
  - out_valid appears exactly one cycle after the 19th term.
- out_ready low for 5 cycles after out_valid, in_valid held high:
  - in_ready=0 throughout; out_data stable.
  - On the handshake, in_ready=1 the next cycle.
  - The next 19 terms produce an independent result.
- Terms and control events:
  - 7 terms of 100, then clear, then 19 terms of 10 → out_data=190.
  - Repeat with reset pulsed after 7 terms instead of clear → all outputs 0 during reset, then out_data=190.
  - clear asserted in HOLD → result unchanged until handshaken.
